// File: rtl/gate_chk_pkg.sv
// Shared types for the gate response checker and its stimulus-side companions.
// Opcode encoding, FSM states and the opcode width.
package gate_chk_pkg;

  localparam int GATE_SEL_W = 3;

  typedef enum logic [GATE_SEL_W-1:0] {
    GATE_AND      = 3'd0,
    GATE_OR       = 3'd1,
    GATE_NOT      = 3'd2,
    GATE_NAND     = 3'd3,
    GATE_NOR      = 3'd4,
    GATE_XOR      = 3'd5,
    GATE_XNOR     = 3'd6,
    GATE_RESERVED = 3'd7
  } gate_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/gate_response_checker_ref.sv
// Combinational golden model: expected gate output for an opcode and inputs.
// The reserved opcode yields 0; callers decide how to treat it.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [GATE_SEL_W-1:0] op,
  input  logic                  a,
  input  logic                  b,
  output logic                  y_exp
);

  always_comb begin
    y_exp = 1'b0;
    case (gate_op_t'(op))
      GATE_AND:  y_exp = a & b;
      GATE_OR:   y_exp = a | b;
      GATE_NOT:  y_exp = ~a;
      GATE_NAND: y_exp = ~(a & b);
      GATE_NOR:  y_exp = ~(a | b);
      GATE_XOR:  y_exp = a ^ b;
      GATE_XNOR: y_exp = ~(a ^ b);
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker: accepts NUM_VEC samples per run, compares against the golden
// model one cycle after acceptance, and keeps saturating pass/fail counts plus first failure.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic                  smp_valid,
  output logic                  smp_ready,
  input  logic                  smp_a,
  input  logic                  smp_b,
  input  logic                  smp_y,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [2:0]            first_fail_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  all_pass,
  output logic                  cfg_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  chk_state_t       state_q, state_d;
  gate_op_t         op_q, op_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic             cmp_a_q, cmp_a_d;
  logic             cmp_b_q, cmp_b_d;
  logic             cmp_y_q, cmp_y_d;
  logic [CNT_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [2:0]       ff_vec_q, ff_vec_d;

  logic y_exp;
  logic cmp_match;
  logic accept;
  logic start_ok;

  gate_ref_model u_ref (
    .op    (op_q),
    .a     (cmp_a_q),
    .b     (cmp_b_q),
    .y_exp (y_exp)
  );

  // A reserved opcode has no golden value, so every sample under it fails.
  assign cmp_match = (op_q != GATE_RESERVED) && (cmp_y_q == y_exp);
  assign accept    = smp_valid && (state_q == RUN);
  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_cnt_d  = acc_cnt_q;
    cmp_vld_d  = 1'b0;
    cmp_a_d    = cmp_a_q;
    cmp_b_d    = cmp_b_q;
    cmp_y_d    = cmp_y_q;
    cmp_idx_d  = cmp_idx_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_idx_d   = ff_idx_q;
    ff_vec_d   = ff_vec_q;

    if (cmp_vld_q) begin
      if (cmp_match) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        if (fail_cnt_q == '0) begin
          ff_idx_d = cmp_idx_q;
          ff_vec_d = {cmp_a_q, cmp_b_q, cmp_y_q};
        end
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d    = RUN;
          op_d       = gate_op_t'(gate_sel);
          acc_cnt_d  = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          ff_idx_d   = '0;
          ff_vec_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cmp_vld_d = 1'b1;
          cmp_a_d   = smp_a;
          cmp_b_d   = smp_b;
          cmp_y_d   = smp_y;
          cmp_idx_d = acc_cnt_q;
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= GATE_AND;
      acc_cnt_q  <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_a_q    <= 1'b0;
      cmp_b_q    <= 1'b0;
      cmp_y_q    <= 1'b0;
      cmp_idx_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_vec_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_cnt_q  <= acc_cnt_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_a_q    <= cmp_a_d;
      cmp_b_q    <= cmp_b_d;
      cmp_y_q    <= cmp_y_d;
      cmp_idx_q  <= cmp_idx_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_idx_q   <= ff_idx_d;
      ff_vec_q   <= ff_vec_d;
    end
  end

  assign smp_ready      = (state_q == RUN);
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign all_pass       = done && (fail_cnt_q == '0);
  assign cfg_err        = (op_q == GATE_RESERVED);
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vec = ff_vec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: three checker instances (NUM_VEC=2, NUM_VEC=4, NUM_VEC=3/CNT_W=2)
// share sample inputs; each is started separately, idle ones ignore samples.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] gate_sel;
  logic       smp_valid, smp_a, smp_b, smp_y;

  logic        rdy2, busy2, done2, ap2, cfg2;
  logic [15:0] pass2, fail2, idx2;
  logic [2:0]  vec2;
  logic        rdy4, busy4, done4, ap4, cfg4;
  logic [15:0] pass4, fail4, idx4;
  logic [2:0]  vec4;
  logic        rdy3, busy3, done3, ap3, cfg3;
  logic [1:0]  pass3, fail3, idx3;
  logic [2:0]  vec3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.NUM_VEC(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .gate_sel(gate_sel),
    .smp_valid(smp_valid), .smp_ready(rdy2), .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
    .pass_cnt(pass2), .fail_cnt(fail2), .first_fail_idx(idx2), .first_fail_vec(vec2),
    .busy(busy2), .done(done2), .all_pass(ap2), .cfg_err(cfg2));

  gate_response_checker #(.NUM_VEC(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .gate_sel(gate_sel),
    .smp_valid(smp_valid), .smp_ready(rdy4), .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
    .pass_cnt(pass4), .fail_cnt(fail4), .first_fail_idx(idx4), .first_fail_vec(vec4),
    .busy(busy4), .done(done4), .all_pass(ap4), .cfg_err(cfg4));

  gate_response_checker #(.NUM_VEC(3), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .gate_sel(gate_sel),
    .smp_valid(smp_valid), .smp_ready(rdy3), .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
    .pass_cnt(pass3), .fail_cnt(fail3), .first_fail_idx(idx3), .first_fail_vec(vec3),
    .busy(busy3), .done(done3), .all_pass(ap3), .cfg_err(cfg3));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int u);
    return (u == 0) ? rdy2 : (u == 1) ? rdy4 : rdy3;
  endfunction

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic do_start(input int u, input logic [2:0] sel);
    start_v[u] = 1'b1;
    gate_sel   = sel;
    @(negedge clk);
    start_v = '0;
  endtask

  // Returns at the falling edge just after the sample was accepted.
  task automatic send(input int u, input logic a, input logic b, input logic y);
    int n = 0;
    smp_valid = 1'b1;
    {smp_a, smp_b, smp_y} = {a, b, y};
    while (!rdy_of(u) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", 32'(rdy_of(u)), 32'd1);
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  logic [2:0] xv [4];
  logic [6:0] pat;
  int j;

  initial begin
    rst = 1'b1; start_v = '0; gate_sel = '0;
    smp_valid = 1'b0; smp_a = 1'b0; smp_b = 1'b0; smp_y = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(rdy4), 0);
    check_eq("rst_busy", 32'(busy4), 0);
    check_eq("rst_done", 32'(done4), 0);
    check_eq("rst_pass", 32'(pass4), 0);
    check_eq("rst_fail", 32'(fail4), 0);
    check_eq("rst_misc", 32'({ap4, cfg4, vec4, idx4}), 0);
    rst = 1'b0;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_valid_pass", 32'(pass4), 0);
    check_eq("idle_valid_busy", 32'(busy4), 0);

    // NOT, NUM_VEC=2
    do_start(0, 3'd2);
    check_eq("not_busy", 32'(busy2), 1);
    check_eq("not_ready", 32'(rdy2), 1);
    send(0, 1'b0, 1'b0, 1'b1);
    send(0, 1'b1, 1'b1, 1'b0);
    check_eq("not_drain_done", 32'(done2), 0);
    check_eq("not_drain_ready", 32'(rdy2), 0);
    @(negedge clk);
    check_eq("not_done", 32'(done2), 1);
    check_eq("not_pass", 32'(pass2), 2);
    check_eq("not_fail", 32'(fail2), 0);
    check_eq("not_all_pass", 32'(ap2), 1);

    // AND with one faulty vector
    do_start(1, 3'd0);
    send(1, 1'b0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b1, 1'b0);
    send(1, 1'b1, 1'b0, 1'b1);
    send(1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("and_done", 32'(done4), 1);
    check_eq("and_pass", 32'(pass4), 3);
    check_eq("and_fail", 32'(fail4), 1);
    check_eq("and_ff_idx", 32'(idx4), 2);
    check_eq("and_ff_vec", 32'(vec4), 32'b101);
    check_eq("and_all_pass", 32'(ap4), 0);

    // XOR with valid gaps, spurious start and gate_sel change mid-run
    xv[0] = 3'b000; xv[1] = 3'b011; xv[2] = 3'b101; xv[3] = 3'b111;
    pat = 7'b1101001;
    do_start(1, 3'd5);
    j = 0;
    for (int i = 0; i < 7; i++) begin
      smp_valid = pat[i];
      if (pat[i]) begin
        {smp_a, smp_b, smp_y} = xv[j];
        j++;
      end
      start_v[1] = (i == 3);
      if (i == 3) gate_sel = 3'd0;
      @(negedge clk);
    end
    smp_valid = 1'b0;
    start_v = '0;
    check_eq("xor_drain_done", 32'(done4), 0);
    @(negedge clk);
    check_eq("xor_done", 32'(done4), 1);
    check_eq("xor_pass", 32'(pass4), 3);
    check_eq("xor_fail", 32'(fail4), 1);
    check_eq("xor_ff_idx", 32'(idx4), 3);
    check_eq("xor_ff_vec", 32'(vec4), 32'b111);

    // Reset mid-run with a compare in flight
    do_start(1, 3'd3);
    send(1, 1'b0, 1'b0, 1'b1);
    send(1, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_pass", 32'(pass4), 0);
    check_eq("mrst_busy", 32'(busy4), 0);
    check_eq("mrst_ready", 32'(rdy4), 0);
    check_eq("mrst_done", 32'(done4), 0);
    do_start(1, 3'd3);
    send(1, 1'b0, 1'b0, 1'b1);
    send(1, 1'b0, 1'b1, 1'b1);
    send(1, 1'b1, 1'b0, 1'b1);
    send(1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("nand_pass", 32'(pass4), 4);
    check_eq("nand_fail", 32'(fail4), 0);
    check_eq("nand_all_pass", 32'(ap4), 1);

    // Reserved opcode, CNT_W=2
    do_start(2, 3'd7);
    check_eq("rsv_cfg_err", 32'(cfg3), 1);
    send(2, 1'b0, 1'b0, 1'b0);
    send(2, 1'b0, 1'b1, 1'b0);
    send(2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("rsv_done", 32'(done3), 1);
    check_eq("rsv_fail", 32'(fail3), 3);
    check_eq("rsv_pass", 32'(pass3), 0);
    check_eq("rsv_all_pass", 32'(ap3), 0);
    do_start(2, 3'd0);
    check_eq("rerun_cfg_err", 32'(cfg3), 0);
    check_eq("rerun_fail", 32'(fail3), 0);
    check_eq("rerun_pass", 32'(pass3), 0);
    send(2, 1'b0, 1'b0, 1'b0);
    send(2, 1'b0, 1'b1, 1'b0);
    send(2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("rerun_pass_end", 32'(pass3), 3);

    // Saturation: preset fail counter to all-ones, then more mismatches
    do_start(2, 3'd7);
    send(2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("sat_first", 32'(fail3), 1);
    force u3.fail_cnt_q = 2'b11;
    @(negedge clk);
    release u3.fail_cnt_q;
    send(2, 1'b0, 1'b1, 1'b0);
    send(2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("sat_done", 32'(done3), 1);
    check_eq("sat_fail", 32'(fail3), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable response checker for the logic-gate verification flow: it is the receiving end of the stimulus/monitor path. It accepts strobed samples of applied gate inputs and observed gate output, compares each against a golden model of the selected gate, and accumulates pass/fail statistics and the first failing vector. It sits downstream of the gate under test, so on-chip or emulated runs self-check without a `$monitor` log.

## Interface
- `NUM_VEC`, default 4: samples per run, ≥1.
- `CNT_W`, default 16: width of counters and index, must satisfy 2^CNT_W > NUM_VEC.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run. Honoured only in IDLE or DONE.
- `gate_sel`  in  3  gate opcode. Sampled on accepted `start` and held for the whole run.
- `smp_valid`  in  1  sample present.
- `smp_ready`  out  1  checker can accept a sample.
- `smp_a`, `smp_b`, `smp_y`  in  1 each  applied inputs and observed output. `smp_b` is ignored for NOT.
- `pass_cnt`, `fail_cnt`  out  CNT_W  saturating result counters.
- `first_fail_idx`  out  CNT_W  sample index (0-based) of the first mismatch.
- `first_fail_vec`  out  3  {a,b,y} of the first mismatch.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `all_pass`  out  1  `done && fail_cnt==0`.
- `cfg_err`  out  1  the latched opcode is reserved.

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 NOT (y = ~a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is reserved. With opcode 7, every sample is counted as a fail and `cfg_err` is set for the run.
- Transfer occurs when `smp_valid && smp_ready`. `smp_valid` may drop at any time; no sample is lost or double-counted.
- FSM:
  - IDLE: `smp_ready`=0. An accepted `start` latches `gate_sel`, clears all results, and moves to RUN.
  - RUN: `smp_ready`=1. Each accepted sample is registered into a compare stage and increments the accepted count. When the count reaches NUM_VEC, the FSM moves to DRAIN.
  - DRAIN: `smp_ready`=0 for exactly one cycle while the last compare retires. Then move to DONE.
  - DONE: results are held stable. `start` clears the results and moves to RUN (a re-run).
- Compare stage: expected = ref(op, a, b).
  - Match: `pass_cnt` +1.
  - Mismatch: `fail_cnt` +1. On the first mismatch only, record `first_fail_idx` and `first_fail_vec`.
- Counters saturate at all-ones and never wrap.
- `start` in RUN or DRAIN is ignored. Latched `gate_sel` changes during a run are ignored.

## Timing
- Reset values: state IDLE; every output 0, including `smp_ready`, counters, `first_fail_*`, `busy`, `done`, `all_pass`, `cfg_err`.
- Latency:
  - A sample accepted at edge k is reflected in the counters after edge k+1.
  - When the last sample is accepted at edge k, DRAIN occupies cycle k..k+1 and `done` is high after edge k+1, coincident with the final counter update.
- `start` accepted at edge s: `busy`=1 and `smp_ready`=1 from after s. A sample can be accepted at edge s+1.
- A `rst` asserted mid-run takes priority over everything at that edge. The in-flight compare is discarded and all outputs return to reset values.
- `cfg_err` is valid from the cycle after `start`.

## Structure
- Package `gate_chk_pkg`: `gate_op_t` enum (codes above, including RESERVED=7), `chk_state_t` enum {IDLE, RUN, DRAIN, DONE}, and a `GATE_SEL_W=3` constant.
- Sub-module `gate_ref_model`: purely combinational (op, a, b → y_exp). It is reused by future stimulus generators.
- Top level: FSM, compare register, counters, first-fail capture. Target 150–250 lines.

## Test plan
- Reset: hold `rst` for 2 cycles. All outputs read 0 and `smp_ready`=0. A `smp_valid` pulse in IDLE changes nothing.
- NOT with NUM_VEC=2: `start`, `gate_sel`=2, samples (a=0,y=1) and (a=1,y=0). Expect `pass_cnt`=2, `fail_cnt`=0, `all_pass`=1, and `done` one edge after the last accept.
- AND with a fault, NUM_VEC=4: vectors ab=00,01,10,11 with y=0,0,1,1. Expect `pass_cnt`=3, `fail_cnt`=1, `first_fail_idx`=2, `first_fail_vec`=3'b101, `all_pass`=0.
- Valid gaps and spurious start:
  - XOR, with `smp_valid` toggled 1,0,0,1,0,1,1.
  - A `start` pulse in the middle of RUN.
  - Expect exactly 4 samples counted, no restart, and `gate_sel` changes mid-run ignored.
- Reset mid-run: assert `rst` after 2 accepted samples. All outputs return to 0 and state is IDLE. A following run counts from 0.
- Reserved opcode and saturation, with CNT_W=2 and NUM_VEC=3 (smallest width satisfying 2^CNT_W > NUM_VEC):
  - `gate_sel`=7 with 3 samples: `cfg_err`=1, `fail_cnt`=3, `pass_cnt`=0.
  - A re-run from DONE with `gate_sel`=0 clears `cfg_err` and the counters.
  - Saturation at all-ones is checked by a bench-forced counter preset of 2'b11 followed by a further mismatch: `fail_cnt` stays 3.
